hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Sequencing controller for the EX-stage operand-forwarding muxes (bit32_mux3to1) of the
//  5-stage pipelined MIPS core. Shadows destination/control info of ID/EX, EX/MEM, MEM/WB.
//  Produces registered 2-bit forward selects for ALU operands A/B. Detects load-use hazards
//  and issues a one-cycle stall (PC/IF-ID hold + ID/EX bubble).
// PARAMETERS
//  REG_AW   5   register-index width (32 GPRs); index 0 is hard-wired zero
//  CNT_W    16  width of stall counter (only with HAZ_PERF_CNT_EN)
// PORTS
//  clk          in   1       core clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  id_valid     in   1       ID stage holds a real instruction
//  id_rs        in   REG_AW  ID source register A
//  id_rt        in   REG_AW  ID source register B
//  id_uses_rt   in   1       instruction reads rt as an operand (R-type, store, beq)
//  id_dest      in   REG_AW  ID destination (post RegDst mux)
//  id_regwrite  in   1       ID instruction writes register file
//  id_memread   in   1       ID instruction is a load
//  flush        in   1       branch/jump taken: squash instruction entering EX
//  fwd_a_sel    out  2       EX mux select A: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB data
//  fwd_b_sel    out  2       EX mux select B, same encoding (11 never driven)
//  stall        out  1       load-use stall: hold PC and IF/ID, bubble into ID/EX
//  stall_cnt    out  CNT_W   saturating stall-cycle count (only with HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (reset_n=0, async): all shadow regs cleared (dest=0, regwrite=0, memread=0);
//    fwd_a_sel=fwd_b_sel=00; stall=0; stall_cnt=0. Reset mid-stall drops the stall at once.
//  - Shadow pipe, every rising edge: wb<=mem; mem<=ex; ex<=ID info if id_valid && !stall &&
//    !flush, else bubble (regwrite=0, memread=0, dest=0).
//  - Match rule: stage S matches src iff S.regwrite && S.dest!=0 && S.dest==src.
//  - Forward select, computed from ID sources vs ex/mem shadows, registered on the same edge
//    that advances ID->EX; valid throughout the instruction's EX cycle (1-cycle latency):
//      ex matches -> 01 (operand in EX/MEM next cycle); else mem matches -> 10; else 00.
//      Nearest producer wins. B select uses id_rt only when id_uses_rt, else 00.
//      On stall, flush, or !id_valid the registered selects load 00.
//  - stall (combinational from shadow regs + ID inputs):
//      ex.memread && ex matches id_rs, or ex.memread && id_uses_rt && ex matches id_rt,
//      gated by id_valid && !flush. Lasts exactly one cycle: next cycle ex is a bubble and
//      the load sits in mem, so consumer is registered with select 10.
//  - flush has priority over stall; flush during a stall squashes the held instruction.
//  - No state beyond the shadow regs; no handshake to upstream besides stall.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt increments each cycle stall=1, saturates at
//    2**CNT_W-1, clears only on reset. Undefined: stall_cnt port absent, no counter flops.
// STRUCTURE
//  Shared package/header: FWD_SEL_RF=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10, REG_ZERO.
//  One sub-module: hazard_src_match (combinational; one source vs ex/mem shadows ->
//  2-bit select + load-hit flag), instantiated twice (A and B).
//  Shadow registers and stall counter stay in the top module.
// TESTING
//  1. add r3,r1,r2 then sub r4,r3,r5 back-to-back -> fwd_a_sel=01 in sub's EX cycle, stall=0.
//  2. add r3 ; nop ; or r6,r7,r3 -> fwd_b_sel=10 in or's EX cycle, fwd_a_sel=00.
//  3. add r3 ; addi r3 ; and r8,r3,r3 -> both selects 01 (nearest producer wins).
//  4. lw r2,0(r1) then add r4,r2,r5 -> stall=1 for exactly 1 cycle, then fwd_a_sel=10, stall=0.
//  5. Producer dest=r0 (regwrite=1) then consumer reads r0 -> selects 00, stall=0.
//  6. Load-use stall with flush=1 same cycle -> stall=0, ex bubbled; reset_n low mid-sequence
//     -> all outputs 0 immediately; with HAZ_PERF_CNT_EN, 3 load-use pairs -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared encodings for the EX-stage forwarding controller.
package hazard_fwd_ctrl_pkg;

  // EX operand mux (bit32_mux3to1) select encoding; 2'b11 is never produced
  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  // GPR index hard-wired to zero; never a real producer
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: compares one ID source register against the ex/mem shadows.
// The nearest producer wins the select. load_hit flags a load in EX that this
// source needs, which cannot be forwarded in time.
module hazard_src_match
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              src_en,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dest,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = src_en && ex_regwrite && (ex_dest != REG_AW'(REG_ZERO)) && (ex_dest == src);
  assign mem_hit = src_en && mem_regwrite && (mem_dest != REG_AW'(REG_ZERO)) && (mem_dest == src);
  assign load_hit = ex_hit && ex_memread;

  // priority select: the younger producer (in EX now) shadows the older one
  always_comb begin
    sel = FWD_SEL_RF;
    if (ex_hit)       sel = FWD_SEL_EXMEM;
    else if (mem_hit) sel = FWD_SEL_MEMWB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding/load-use controller for the 5-stage MIPS EX stage.
// Shadows dest/control of the instructions in EX and MEM, registers forward
// selects one cycle ahead of use, and raises a one-cycle load-use stall.
// Optional build macro HAZ_PERF_CNT_EN adds the saturating stall_cnt output
// and its CNT_W parameter.
// A WB shadow is not kept: selects are computed while the consumer is still in
// ID, so the ex/mem shadows already cover the EX/MEM and MEM/WB mux inputs.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              stall
);

  localparam int NUM_SRC = 2;  // lane 0 = rs (operand A), lane 1 = rt (operand B)

  // shadow registers of the instructions now in EX and MEM
  logic              ex_regwrite, ex_memread;
  logic [REG_AW-1:0] ex_dest;
  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_dest;

  logic [NUM_SRC-1:0][REG_AW-1:0] src;
  logic [NUM_SRC-1:0]             src_en;
  logic [NUM_SRC-1:0][1:0]        sel;
  logic [NUM_SRC-1:0]             load_hit;
  logic                           advance;

  assign src    = {id_rt, id_rs};
  assign src_en = {id_uses_rt, 1'b1};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(.REG_AW(REG_AW)) u_match (
      .src_en       (src_en[i]),
      .src          (src[i]),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_dest      (ex_dest),
      .mem_regwrite (mem_regwrite),
      .mem_dest     (mem_dest),
      .sel          (sel[i]),
      .load_hit     (load_hit[i])
    );
  end

  // flush outranks stall: a squashed consumer never needs to wait
  assign stall   = id_valid && !flush && (|load_hit);
  assign advance = id_valid && !stall && !flush;

  // shadow pipe: ID->EX takes a bubble unless a real instruction advances
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_dest      <= '0;
      mem_regwrite <= 1'b0;
      mem_dest     <= '0;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_dest     <= ex_dest;
      if (advance) begin
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_dest     <= id_dest;
      end else begin
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_dest     <= '0;
      end
    end
  end

  // forward selects registered on the ID->EX edge, held for the EX cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a_sel <= FWD_SEL_RF;
      fwd_b_sel <= FWD_SEL_RF;
    end else if (advance) begin
      fwd_a_sel <= sel[0];
      fwd_b_sel <= sel[1];
    end else begin
      fwd_a_sel <= FWD_SEL_RF;
      fwd_b_sel <= FWD_SEL_RF;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // saturating count of stall cycles, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
